// File: rtl/key_move_decoder_pkg.sv
// Shared definitions for the keyboard-to-movement decoder: parser states,
// PS/2 set-2 scan codes used by the game, and the direction type.
package key_move_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } parser_state_t;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } dir_t;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_TOM_L = 8'h6B;
  localparam logic [7:0] SC_TOM_R = 8'h74;
  localparam logic [7:0] SC_TOM_J = 8'h75;
  localparam logic [7:0] SC_JER_L = 8'h1C;
  localparam logic [7:0] SC_JER_R = 8'h23;
  localparam logic [7:0] SC_JER_J = 8'h1D;

endpackage

// File: rtl/key_move_decoder_key_state.sv
// Per-player held-key tracking, left/right arbitration by most recent make,
// and a minimum-width jump stretcher; outputs are registered and gated.
module player_key_state
  import key_move_decoder_pkg::*;
#(
  parameter int JUMP_MIN_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic make_l,
  input  logic brk_l,
  input  logic make_r,
  input  logic brk_r,
  input  logic make_j,
  input  logic brk_j,
  input  logic game_active,
  output logic left,
  output logic right,
  output logic jump
);

  localparam int CW = $clog2(JUMP_MIN_CYCLES + 1);

  logic          held_l, held_r, held_j;
  logic          held_l_n, held_r_n, held_j_n;
  dir_t          last_dir, last_dir_n;
  logic [CW-1:0] jump_cnt, jump_cnt_n;
  logic          left_n, right_n, jump_n;

  // Outputs are computed from the post-event state so a change shows up
  // one cycle after the strobe, not two.
  always_comb begin
    held_l_n   = held_l;
    held_r_n   = held_r;
    held_j_n   = held_j;
    last_dir_n = last_dir;
    jump_cnt_n = jump_cnt;

    if (make_l)     held_l_n = 1'b1;
    else if (brk_l) held_l_n = 1'b0;
    if (make_r)     held_r_n = 1'b1;
    else if (brk_r) held_r_n = 1'b0;
    if (make_j)     held_j_n = 1'b1;
    else if (brk_j) held_j_n = 1'b0;

    if (make_l)      last_dir_n = LEFT;
    else if (make_r) last_dir_n = RIGHT;

    if (make_j)                jump_cnt_n = CW'(JUMP_MIN_CYCLES);
    else if (jump_cnt != '0)   jump_cnt_n = jump_cnt - CW'(1);

    left_n  = held_l_n && (!held_r_n || last_dir_n == LEFT);
    right_n = held_r_n && (!held_l_n || last_dir_n == RIGHT);
    jump_n  = held_j_n || (jump_cnt_n != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_l   <= 1'b0;
      held_r   <= 1'b0;
      held_j   <= 1'b0;
      last_dir <= LEFT;
      jump_cnt <= '0;
      left     <= 1'b0;
      right    <= 1'b0;
      jump     <= 1'b0;
    end else begin
      held_l   <= held_l_n;
      held_r   <= held_r_n;
      held_j   <= held_j_n;
      last_dir <= last_dir_n;
      jump_cnt <= jump_cnt_n;
      left     <= left_n  & game_active;
      right    <= right_n & game_active;
      jump     <= jump_n  & game_active;
    end
  end

endmodule

// File: rtl/key_move_decoder.sv
// PS/2 set-2 scan-byte parser feeding two player key-state blocks:
// Tom on extended arrow keys, Jerry on plain W/A/D.
module key_move_decoder
  import key_move_decoder_pkg::*;
#(
  parameter int JUMP_MIN_CYCLES = 1_000_000,
  parameter int PREFIX_TIMEOUT  = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  input  logic       game_active,
  output logic       tom_left,
  output logic       tom_right,
  output logic       tom_jump,
  output logic       jerry_left,
  output logic       jerry_right,
  output logic       jerry_jump
);

  localparam int TW = $clog2(PREFIX_TIMEOUT + 1);

  parser_state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic          ev_make, ev_brk, ev_ext;

  // A stalled prefix (lost byte) times out back to IDLE without a key event;
  // a byte arriving on the timeout cycle is still parsed in the prefix state.
  always_comb begin
    state_n = state;
    timer_n = timer;
    ev_make = 1'b0;
    ev_brk  = 1'b0;
    ev_ext  = 1'b0;
    if (scan_valid) begin
      timer_n = '0;
      case (state)
        IDLE: begin
          if (scan_code == SC_EXT)      state_n = EXT;
          else if (scan_code == SC_BRK) state_n = BRK;
          else                          ev_make = 1'b1;
        end
        EXT: begin
          if (scan_code == SC_BRK) begin
            state_n = EXT_BRK;
          end else begin
            ev_make = 1'b1;
            ev_ext  = 1'b1;
            state_n = IDLE;
          end
        end
        BRK: begin
          ev_brk  = 1'b1;
          state_n = IDLE;
        end
        EXT_BRK: begin
          ev_brk  = 1'b1;
          ev_ext  = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE) begin
      if (timer == TW'(PREFIX_TIMEOUT - 1)) begin
        state_n = IDLE;
        timer_n = '0;
      end else begin
        timer_n = timer + TW'(1);
      end
    end else begin
      timer_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_n;
      timer <= timer_n;
    end
  end

  logic tom_ev, jer_ev;
  assign tom_ev = ev_ext;
  assign jer_ev = !ev_ext;

  player_key_state #(.JUMP_MIN_CYCLES(JUMP_MIN_CYCLES)) u_tom (
    .clk         (clk),
    .rst         (rst),
    .make_l      (ev_make && tom_ev && scan_code == SC_TOM_L),
    .brk_l       (ev_brk  && tom_ev && scan_code == SC_TOM_L),
    .make_r      (ev_make && tom_ev && scan_code == SC_TOM_R),
    .brk_r       (ev_brk  && tom_ev && scan_code == SC_TOM_R),
    .make_j      (ev_make && tom_ev && scan_code == SC_TOM_J),
    .brk_j       (ev_brk  && tom_ev && scan_code == SC_TOM_J),
    .game_active (game_active),
    .left        (tom_left),
    .right       (tom_right),
    .jump        (tom_jump)
  );

  player_key_state #(.JUMP_MIN_CYCLES(JUMP_MIN_CYCLES)) u_jerry (
    .clk         (clk),
    .rst         (rst),
    .make_l      (ev_make && jer_ev && scan_code == SC_JER_L),
    .brk_l       (ev_brk  && jer_ev && scan_code == SC_JER_L),
    .make_r      (ev_make && jer_ev && scan_code == SC_JER_R),
    .brk_r       (ev_brk  && jer_ev && scan_code == SC_JER_R),
    .make_j      (ev_make && jer_ev && scan_code == SC_JER_J),
    .brk_j       (ev_brk  && jer_ev && scan_code == SC_JER_J),
    .game_active (game_active),
    .left        (jerry_left),
    .right       (jerry_right),
    .jump        (jerry_jump)
  );

endmodule

// File: tb/tb_key_move_decoder.sv
// Directed and random scan-byte stimulus checked every cycle against a
// behavioural model of key press/release semantics.
module tb_key_move_decoder;

  localparam int JMIN = 50;
  localparam int PTO  = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic       game_active = 1'b1;
  logic       tom_left, tom_right, tom_jump;
  logic       jerry_left, jerry_right, jerry_jump;

  int errors = 0;
  int checks = 0;

  key_move_decoder #(.JUMP_MIN_CYCLES(JMIN), .PREFIX_TIMEOUT(PTO)) dut (
    .clk         (clk),
    .rst         (rst),
    .scan_code   (scan_code),
    .scan_valid  (scan_valid),
    .game_active (game_active),
    .tom_left    (tom_left),
    .tom_right   (tom_right),
    .tom_jump    (tom_jump),
    .jerry_left  (jerry_left),
    .jerry_right (jerry_right),
    .jerry_jump  (jerry_jump)
  );

  always #5 clk = ~clk;

  // Model: player 0 = Tom, 1 = Jerry; key 0 = left, 1 = right, 2 = jump.
  bit         held [2][3];
  int         last_right [2];
  int         jump_left [2];
  bit         saw_e0, saw_f0;
  int         quiet;
  logic [5:0] exp_outs;

  function automatic void model_reset();
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 3; k++) held[p][k] = 0;
      last_right[p] = 0;
      jump_left[p]  = 0;
    end
    saw_e0 = 0; saw_f0 = 0; quiet = 0;
    exp_outs = '0;
  endfunction

  function automatic void key_event(bit ext, bit brk, logic [7:0] b);
    int p, k;
    p = -1; k = -1;
    if (ext) begin
      if (b == 8'h6B) begin p = 0; k = 0; end
      if (b == 8'h74) begin p = 0; k = 1; end
      if (b == 8'h75) begin p = 0; k = 2; end
    end else begin
      if (b == 8'h1C) begin p = 1; k = 0; end
      if (b == 8'h23) begin p = 1; k = 1; end
      if (b == 8'h1D) begin p = 1; k = 2; end
    end
    if (p < 0) return;
    if (brk) begin
      held[p][k] = 0;
    end else begin
      held[p][k] = 1;
      if (k == 0) last_right[p] = 0;
      if (k == 1) last_right[p] = 1;
      if (k == 2) jump_left[p] = JMIN;
    end
  endfunction

  function automatic void model_edge(bit v, logic [7:0] b, bit ga);
    logic [2:0] o [2];
    for (int p = 0; p < 2; p++) if (jump_left[p] > 0) jump_left[p]--;
    if (v) begin
      quiet = 0;
      if (!saw_e0 && !saw_f0 && b == 8'hE0) saw_e0 = 1;
      else if (!saw_f0 && b == 8'hF0)       saw_f0 = 1;
      else begin
        key_event(saw_e0, saw_f0, b);
        saw_e0 = 0; saw_f0 = 0;
      end
    end else if (saw_e0 || saw_f0) begin
      quiet++;
      if (quiet == PTO) begin
        saw_e0 = 0; saw_f0 = 0; quiet = 0;
      end
    end
    for (int p = 0; p < 2; p++) begin
      o[p][2] = held[p][0] && (!held[p][1] || last_right[p] == 0);
      o[p][1] = held[p][1] && (!held[p][0] || last_right[p] == 1);
      o[p][0] = held[p][2] || (jump_left[p] > 0);
    end
    exp_outs = {o[0], o[1]} & {6{ga}};
  endfunction

  function automatic logic [5:0] outs();
    return {tom_left, tom_right, tom_jump, jerry_left, jerry_right, jerry_jump};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic step(input bit v, input logic [7:0] b);
    scan_valid = v;
    scan_code  = b;
    @(posedge clk);
    model_edge(v, b, game_active);
    #1;
    scan_valid = 1'b0;
    check("outputs", 32'(outs()), 32'(exp_outs));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
    check("reset_outputs", 32'(outs()), 32'(0));
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b);
  endtask

  logic [7:0] pool [8];
  int         hi;
  logic [7:0] b;

  initial begin
    pool = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h75, 8'h1C, 8'h23, 8'h1D};
    #1;
    do_reset();
    repeat (100) step(1'b0, 8'h00);

    // Jerry left make/break
    send(8'h1C);
    check("jerry_left_make", 32'(jerry_left), 32'(1));
    step(1'b0, 8'h00);
    send(8'hF0); send(8'h1C);
    check("jerry_left_break", 32'(jerry_left), 32'(0));
    check("tom_quiet", 32'({tom_left, tom_right, tom_jump}), 32'(0));
    repeat (3) step(1'b0, 8'h00);

    // Tom left, then right overrides, then release right returns left
    send(8'hE0); send(8'h6B);
    check("tom_left_held", 32'(tom_left), 32'(1));
    send(8'hE0); send(8'h74);
    check("tom_right_wins", 32'({tom_left, tom_right}), 32'(2'b01));
    send(8'hE0); send(8'hF0); send(8'h74);
    check("tom_left_back", 32'({tom_left, tom_right}), 32'(2'b10));
    send(8'hE0); send(8'hF0); send(8'h6B);
    repeat (3) step(1'b0, 8'h00);

    // Jerry jump stretched to the minimum width
    hi = 0;
    send(8'h1D);          hi += int'(jerry_jump);
    step(1'b0, 8'h00);    hi += int'(jerry_jump);
    send(8'hF0);          hi += int'(jerry_jump);
    send(8'h1D);          hi += int'(jerry_jump);
    repeat (60) begin step(1'b0, 8'h00); hi += int'(jerry_jump); end
    check("jump_width", 32'(hi), 32'(JMIN));

    // Stalled E0 times out; following 6B is a plain code
    send(8'hE0);
    repeat (PTO + 2) step(1'b0, 8'h00);
    send(8'h6B);
    check("timeout_no_tom", 32'({tom_left, tom_right, tom_jump}), 32'(0));
    step(1'b0, 8'h00);

    // Byte arriving on the timeout cycle is still parsed as extended
    send(8'hE0);
    repeat (PTO - 1) step(1'b0, 8'h00);
    send(8'h6B);
    check("late_ext_make", 32'(tom_left), 32'(1));
    send(8'hE0); send(8'hF0); send(8'h6B);

    // Reset right after E0: next byte is plain
    send(8'hE0);
    do_reset();
    send(8'h6B);
    check("reset_mid_prefix", 32'(tom_left), 32'(0));

    // Gating keeps held state
    send(8'h23);
    check("jerry_right_held", 32'(jerry_right), 32'(1));
    game_active = 1'b0;
    step(1'b0, 8'h00);
    check("gated_off", 32'(jerry_right), 32'(0));
    repeat (3) step(1'b0, 8'h00);
    game_active = 1'b1;
    step(1'b0, 8'h00);
    check("gated_on", 32'(jerry_right), 32'(1));
    send(8'hF0); send(8'h23);

    // Random byte streams with gaps, gating changes and rare resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) game_active = ~game_active;
      if ($urandom_range(0, 150) == 0) do_reset();
      if ($urandom_range(0, 4) == 0) b = 8'($urandom_range(0, 255));
      else b = pool[$urandom_range(0, 7)];
      send(b);
      if ($urandom_range(0, 25) == 0) repeat (PTO + $urandom_range(0, 3)) step(1'b0, 8'h00);
      else repeat ($urandom_range(0, 3)) step(1'b0, 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
